rr_bus_arbiter: RTL

- Round-robin arbiter sharing one downstream streaming channel between NUM_REQ upstream requesters. Default NUM_REQ=3 covers the SV, VHDL and Verilog-simulation-model RTL tops.
- Sits between the RTL tops and the shared sink. It grants one requester per packet and muxes that requester's valid/data/last onto the sink.
- The grant is held until the packet's last beat is accepted, so packets are never interleaved.

---
 rtl/rr_bus_arbiter_pkg.sv | 47 ++++
 rtl/rr_prio_pick.sv | 40 ++++
 rtl/rr_bus_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rr_bus_arbiter_pkg.sv
// ============================================================================
//  Module      : rr_bus_arbiter_pkg
//  Description : Shared types and round-robin pick helpers for rr_bus_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_bus_arbiter_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First set bit of req at or after ptr, wrapping modulo n; one-hot result.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] oh;
        logic               found;
        int                 idx;
        oh    = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((k < n) && !found && req[idx[2:0]]) begin
                oh[idx[2:0]] = 1'b1;
                found        = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_prio_pick.sv
// ============================================================================
//  Module      : rr_prio_pick
//  Description : Combinational rotating priority pick: one-hot winner plus index.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_prio_pick
    import rr_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               any,
    output logic [NUM_REQ-1:0] oh,
    output logic [ID_W-1:0]    id
);

    logic [MAX_REQ-1:0] w_req_ext;
    logic [MAX_REQ-1:0] w_pick_full;

    assign w_req_ext   = MAX_REQ'(req);
    assign w_pick_full = rr_pick(w_req_ext, 3'(ptr), NUM_REQ);
    assign any         = |w_pick_full;
    assign oh          = w_pick_full[NUM_REQ-1:0];

    always_comb begin
        id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_bus_arbiter.sv
// ============================================================================
//  Module      : rr_bus_arbiter
//  Description : Packet-level round-robin arbiter muxing NUM_REQ streams to one sink.
//                Define RR_BUS_ARBITER_WDOG_EN to enable the stalled-packet watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_bus_arbiter
    import rr_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int DATA_W   = 32,
    parameter int WDOG_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        snk_valid,
    output logic [DATA_W-1:0]           snk_data,
    output logic                        snk_last,
    input  logic                        snk_ready,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [$clog2(NUM_REQ)-1:0]  gnt_id,
    output logic                        busy,
    output logic                        wdog_err
);

    localparam int GNT_ID_W = id_width(NUM_REQ);

    generate
        if ((NUM_REQ < 2) || (NUM_REQ > MAX_REQ) || (WDOG_CYC < 2)) begin : g_bad_param
            $error("rr_bus_arbiter: NUM_REQ must be 2..8 and WDOG_CYC >= 2");
        end
    endgenerate

    arb_state_t            r_state;
    logic [NUM_REQ-1:0]    r_gnt;
    logic [GNT_ID_W-1:0]   r_gnt_id;
    logic [GNT_ID_W-1:0]   r_ptr;

    logic                  w_any;
    logic [NUM_REQ-1:0]    w_pick_oh;
    logic [GNT_ID_W-1:0]   w_pick_id;
    logic                  w_xfer;
    logic                  w_wdog_fire;
    logic                  w_release;
    logic [GNT_ID_W-1:0]   w_next_ptr;

    rr_prio_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (GNT_ID_W)
    ) u_pick (
        .req (req_valid),
        .ptr (r_ptr),
        .any (w_any),
        .oh  (w_pick_oh),
        .id  (w_pick_id)
    );

    // Grant is zero outside BUSY, so the mux naturally drives zeros when idle.
    always_comb begin
        snk_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_gnt[i]) begin
                snk_data = snk_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign snk_valid  = |(req_valid & r_gnt);
    assign snk_last   = |(req_last & r_gnt);
    assign req_ready  = r_gnt & {NUM_REQ{snk_ready}};
    assign gnt        = r_gnt;
    assign gnt_id     = r_gnt_id;
    assign busy       = (r_state == BUSY);

    assign w_xfer     = snk_valid & snk_ready;
    assign w_release  = (w_xfer & snk_last) | w_wdog_fire;
    assign w_next_ptr = (r_gnt_id == GNT_ID_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + GNT_ID_W'(1);

`ifdef RR_BUS_ARBITER_WDOG_EN
    localparam int WDOG_W = (WDOG_CYC <= 2) ? 1 : $clog2(WDOG_CYC);

    logic [WDOG_W-1:0] r_wdog_cnt;
    logic              r_wdog_err;

    assign w_wdog_fire = (r_state == BUSY) && !w_xfer && (r_wdog_cnt == WDOG_W'(WDOG_CYC - 1));
    assign wdog_err    = r_wdog_err;

    // Counts consecutive BUSY cycles without a beat; cleared on grant and on every beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            r_wdog_err <= w_wdog_fire;
            if ((r_state == IDLE) || w_xfer || w_wdog_fire) begin
                r_wdog_cnt <= '0;
            end else begin
                r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
            end
        end
    end
`else
    assign w_wdog_fire = 1'b0;
    assign wdog_err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_ptr    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt    <= w_pick_oh;
                        r_gnt_id <= w_pick_id;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_release) begin
                        r_gnt    <= '0;
                        r_gnt_id <= '0;
                        r_ptr    <= w_next_ptr;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
